// File: rtl/fetch_pipeline.sv
// Instruction fetch front end: fetches opcodes and one-word immediates into a STAGES-deep control pipeline.
// An opcode accepted at edge k sits in stage i after edge k+i. STALL freezes PC, state and pipeline and deasserts MEM_RD.
module fetch_pipeline #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    STAGES       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE  = 8'h01,
  parameter int                    IMM_BIT      = 7
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
  output logic                         MEM_RD,
  input  logic [DATA_WIDTH-1:0]        MEM_DATA,
  input  logic                         MEM_READY,
  input  logic                         STALL,
  input  logic                         FLUSH,
  input  logic                         JUMP,
  input  logic [ADDR_WIDTH-1:0]        JUMP_ADDR,
  output logic [ADDR_WIDTH-1:0]        PC,
  output logic [STAGES*DATA_WIDTH-1:0] STAGE_OPCODE,
  output logic [STAGES-1:0]            STAGE_VALID,
  output logic [DATA_WIDTH-1:0]        CONST_OUT,
  output logic                         CONST_LOAD,
  output logic                         HALT
);

  typedef enum logic [1:0] {S_FETCH_OP, S_FETCH_IMM, S_DRAIN, S_HALTED} state_t;

  state_t                              state_q;
  logic [ADDR_WIDTH-1:0]               pc_q;
  logic [DATA_WIDTH-1:0]               pend_q;
  logic [STAGES-1:0][DATA_WIDTH-1:0]   stage_op_q;
  logic [STAGES-1:0]                   stage_vld_q;
  logic [DATA_WIDTH-1:0]               const_q;
  logic                                const_load_q;
  logic                                halt_q;

  logic                                accept;
  logic                                kill;
  logic                                disp_vld;
  logic                                disp_halt;
  logic [DATA_WIDTH-1:0]               disp_op;
  logic [STAGES-1:0][DATA_WIDTH-1:0]   stage_op_d;
  logic [STAGES-1:0]                   stage_vld_d;

  assign MEM_RD   = ((state_q == S_FETCH_OP) || (state_q == S_FETCH_IMM)) && !STALL;
  assign accept   = MEM_RD && MEM_READY;
  assign kill     = (state_q != S_HALTED) && (FLUSH || JUMP);

  always_comb begin
    disp_vld = 1'b0;
    disp_op  = '0;
    if (accept) begin
      if (state_q == S_FETCH_OP && !MEM_DATA[IMM_BIT]) begin
        disp_vld = 1'b1;
        disp_op  = MEM_DATA;
      end else if (state_q == S_FETCH_IMM) begin
        disp_vld = 1'b1;
        disp_op  = pend_q;
      end
    end
    disp_halt = disp_vld && (disp_op == HALT_OPCODE);
  end

  // Shifted pipeline image; a jump or flush edge discards any dispatch by injecting a bubble.
  always_comb begin
    stage_op_d  = '0;
    stage_vld_d = '0;
    for (int i = 1; i < STAGES; i++) begin
      stage_op_d[i]  = stage_op_q[i-1];
      stage_vld_d[i] = stage_vld_q[i-1];
    end
    stage_op_d[0]  = kill ? '0 : disp_op;
    stage_vld_d[0] = !kill && disp_vld;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_FETCH_OP;
      pc_q         <= RESET_VECTOR;
      pend_q       <= '0;
      stage_op_q   <= '0;
      stage_vld_q  <= '0;
      const_q      <= '0;
      const_load_q <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      const_load_q <= 1'b0;

      if (kill && FLUSH) begin
        stage_op_q  <= '0;
        stage_vld_q <= '0;
      end else if (!STALL) begin
        stage_op_q  <= stage_op_d;
        stage_vld_q <= stage_vld_d;
      end

      if (kill) begin
        pend_q  <= '0;
        state_q <= S_FETCH_OP;
        if (JUMP) pc_q <= JUMP_ADDR;
      end else if (!STALL) begin
        if (accept) begin
          pc_q <= pc_q + ADDR_WIDTH'(1);
          if (state_q == S_FETCH_OP && MEM_DATA[IMM_BIT]) begin
            pend_q  <= MEM_DATA;
            state_q <= S_FETCH_IMM;
          end else if (state_q == S_FETCH_IMM) begin
            const_q      <= MEM_DATA;
            const_load_q <= 1'b1;
            pend_q       <= '0;
            state_q      <= S_FETCH_OP;
          end
        end
        if (disp_halt) state_q <= S_DRAIN;
        // Halt only once the draining halt opcode reaches the last stage (same edge it is dispatched when STAGES==1).
        if (stage_vld_d[STAGES-1] && stage_op_d[STAGES-1] == HALT_OPCODE &&
            (state_q == S_DRAIN || disp_halt)) begin
          state_q <= S_HALTED;
          halt_q  <= 1'b1;
        end
      end
    end
  end

  assign MEM_ADDR     = pc_q;
  assign PC           = pc_q;
  assign STAGE_OPCODE = stage_op_q;
  assign STAGE_VALID  = stage_vld_q;
  assign CONST_OUT    = const_q;
  assign CONST_LOAD   = const_load_q;
  assign HALT         = halt_q;

endmodule
